// File: rtl/dispatch_issue_ctrl.sv
// Dispatch/issue controller: in-order instruction FIFO whose head issues only when its sources are free.
// Latency: two edges minimum (enqueue write edge, then registered issue edge); an entry is never bypassed.
// Backpressure: enq_ready = !full; the head holds on a RAW hazard, stall_in or flush.
module dispatch_issue_ctrl #(
  parameter int CORE  = 0,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enq_valid,
  input  logic [31:0]   enq_instr,
  output logic          enq_ready,
  input  logic          id_valid,
  input  logic          exe_valid,
  input  logic          mem_valid,
  input  logic          wb_valid,
  input  logic [4:0]    id_dest,
  input  logic [4:0]    exe_dest,
  input  logic [4:0]    mem_dest,
  input  logic [4:0]    wb_dest,
  input  logic          stall_in,
  input  logic          flush,
  output logic          issue_valid,
  output logic [31:0]   issue_instr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [1:0]    state,
  output logic [15:0]   stall_cnt
);

  // The queue geometry relies on pointer wrap by truncation, so DEPTH must be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CORE < 0) begin : g_param_err
    $error("dispatch_issue_ctrl: DEPTH must be a power of two >= 2 and CORE non-negative");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [AW:0] LP_FULL = DEPTH[AW:0];

  // Storage and registered state.
  logic [31:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]  r_count;
  logic         r_issue_valid;
  logic [31:0]  r_issue_instr;
  logic [15:0]  r_stall_cnt;
  state_t       r_state;

  // Combinational helpers.
  logic [31:0]  w_head_instr;
  logic [31:0]  w_head_instr_nxt;
  logic         w_full;
  logic         w_not_empty;
  logic         w_hazard;
  logic         w_issue;
  logic         w_enq;
  logic         w_blocked_nxt;
  logic [AW-1:0] w_head_nxt;
  logic [AW-1:0] w_tail_nxt;
  logic [AW:0]  w_count_nxt;
  state_t       w_state_nxt;
  state_t       w_state_cur;

  // One source operand against one producer; x0 is never a dependency.
  function automatic logic f_src_haz(input logic [4:0] src,
                                     input logic       iss_vld,
                                     input logic [4:0] iss_rd);
    logic hit;
    hit = (id_valid  && (src == id_dest))  ||
          (exe_valid && (src == exe_dest)) ||
          (mem_valid && (src == mem_dest)) ||
          (wb_valid  && (src == wb_dest))  ||
          (iss_vld && (iss_rd != 5'd0) && (src == iss_rd));
    return (src != 5'd0) && hit;
  endfunction

  // rs1/rs2 are taken from fixed positions for every format; unused fields only cause extra stalls.
  function automatic logic f_blocked(input logic [31:0] instr,
                                     input logic        iss_vld,
                                     input logic [4:0]  iss_rd);
    return f_src_haz(instr[19:15], iss_vld, iss_rd) ||
           f_src_haz(instr[24:20], iss_vld, iss_rd);
  endfunction

  // Head decode, hazard check and handshake qualification.
  always_comb begin
    w_head_instr = r_mem[r_head];
    w_full       = (r_count == LP_FULL);
    // EMPTY state is held exactly when the count is zero, so it doubles as the occupancy flag.
    w_not_empty  = (r_state != ST_EMPTY);
    w_hazard     = f_blocked(w_head_instr, r_issue_valid, r_issue_instr[11:7]);
    w_issue      = w_not_empty && !w_hazard && !stall_in && !flush;
    w_enq        = enq_valid && !w_full && !flush;
  end

  // Pointer and occupancy update; flush discards everything including this cycle's enqueue.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (flush) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_issue) w_head_nxt = r_head + AW'(1);
      if (w_enq)   w_tail_nxt = r_tail + AW'(1);
      case ({w_enq, w_issue})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Next-state: look at the entry that will sit at the head after this edge.
  always_comb begin
    w_head_instr_nxt = r_mem[w_head_nxt];
    // A lone entry written this edge is not in storage yet; take it straight from the port.
    if (w_enq && (w_head_nxt == r_tail)) w_head_instr_nxt = enq_instr;
    w_blocked_nxt = stall_in ||
                    f_blocked(w_head_instr_nxt, w_issue, w_head_instr[11:7]);
    w_state_nxt = ST_READY;
    if (w_count_nxt == '0)  w_state_nxt = ST_EMPTY;
    else if (w_blocked_nxt) w_state_nxt = ST_STALL;
  end

  // Reported state describes the present cycle: occupancy plus whether the head is held now.
  always_comb begin
    w_state_cur = ST_READY;
    if (r_count == '0)              w_state_cur = ST_EMPTY;
    else if (w_hazard || stall_in)  w_state_cur = ST_STALL;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Queue storage; contents are don't-care after reset because pointers and count restart.
  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_tail] <= enq_instr;
  end

  // Pointers, occupancy and the registered issue slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_issue_valid <= 1'b0;
      r_issue_instr <= '0;
    end else begin
      r_head        <= w_head_nxt;
      r_tail        <= w_tail_nxt;
      r_count       <= w_count_nxt;
      r_issue_valid <= w_issue;
      if (w_issue) r_issue_instr <= w_head_instr;
    end
  end

  // Saturating count of edges where work was waiting but nothing issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_not_empty && !w_issue && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign enq_ready   = !w_full;
  assign issue_valid = r_issue_valid;
  assign issue_instr = r_issue_instr;
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = (r_count == '0);
  assign state       = w_state_cur;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_dispatch_issue_ctrl.sv
// Directed bench for dispatch_issue_ctrl with an in-order expected-issue queue.
// Stimulus drives #1 after the rising edge; an issue monitor samples #2 after the edge.
// Every issue seen is popped from the expected queue and compared.
module tb_dispatch_issue_ctrl;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic [31:0] enq_instr;
  logic        enq_ready;
  logic        id_valid, exe_valid, mem_valid, wb_valid;
  logic [4:0]  id_dest, exe_dest, mem_dest, wb_dest;
  logic        stall_in;
  logic        flush;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] v;

  dispatch_issue_ctrl #(.CORE(0), .DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .enq_valid   (enq_valid),
    .enq_instr   (enq_instr),
    .enq_ready   (enq_ready),
    .id_valid    (id_valid),
    .exe_valid   (exe_valid),
    .mem_valid   (mem_valid),
    .wb_valid    (wb_valid),
    .id_dest     (id_dest),
    .exe_dest    (exe_dest),
    .mem_dest    (mem_dest),
    .wb_dest     (wb_dest),
    .stall_in    (stall_in),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .state       (state),
    .stall_cnt   (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Simple instruction with rd/rs1/rs2 all x0 so it never creates or suffers a hazard.
  function automatic logic [31:0] plain(input int k);
    return 32'h0000_0013 | (32'(k + 1) << 25);
  endfunction

  // Issue monitor: each issued instruction must be the oldest outstanding expectation.
  always @(posedge clock) begin
    #2;
    if (reset === 1'b1 && issue_valid === 1'b1) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL issue_unexpected: observed %08h expected no issue", issue_instr);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        n_tests++;
        assert (issue_instr === mon_exp) else begin
          n_fail++;
          $error("FAIL issue_order: observed %08h expected %08h", issue_instr, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enq_valid = 1'b0; enq_instr = '0;
    id_valid = 1'b0; exe_valid = 1'b0; mem_valid = 1'b0; wb_valid = 1'b0;
    id_dest = '0; exe_dest = '0; mem_dest = '0; wb_dest = '0;
    stall_in = 1'b0; flush = 1'b0;

    // Reset values.
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_state", state, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_enq_ready", enq_ready, 1);

    // Single instruction, idle pipeline; enqueue on the first edge after reset release.
    enq_valid = 1'b1; enq_instr = 32'h0020_8133; exp_q.push_back(32'h0020_8133);
    #1 reset = 1'b1;
    tick();
    enq_valid = 1'b0;
    chk("t1_count_after_enq", count, 1);
    chk("t1_state_ready", state, 1);
    chk("t1_no_bypass", issue_valid, 0);
    tick();
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_count_zero", count, 0);
    chk("t1_empty", empty, 1);
    tick();
    chk("t1_valid_drops", issue_valid, 0);
    chk("t1_instr_holds", issue_instr, 32'h0020_8133);

    // RAW hazard on rs1=x5 from EXE for three edges.
    #2 reset = 1'b0; exp_q.delete();
    #2 reset = 1'b1;
    exe_valid = 1'b1; exe_dest = 5'd5;
    enq_valid = 1'b1; enq_instr = 32'h0012_8313; exp_q.push_back(32'h0012_8313);
    tick();
    enq_valid = 1'b0;
    chk("t2_state_stall", state, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_no_issue", issue_valid, 0);
    end
    chk("t2_stall_cnt", stall_cnt, 3);
    // rs2 field (imm bits) is x1: a WB producer of x1 also blocks.
    exe_valid = 1'b0; wb_valid = 1'b1; wb_dest = 5'd1;
    #1 chk("t2_wb_rs2_stall", state, 2);
    wb_valid = 1'b0;
    #1 chk("t2_state_ready", state, 1);
    tick();
    chk("t2_issue", issue_valid, 1);
    chk("t2_stall_cnt_hold", stall_cnt, 3);
    chk("t2_count_zero", count, 0);

    // Back-to-back dependent pair: second blocked by the issue slot's rd=x3.
    enq_valid = 1'b1; enq_instr = 32'h0070_0193; exp_q.push_back(32'h0070_0193);
    tick();
    chk("t3_count_a", count, 1);
    enq_instr = 32'h0001_8233; exp_q.push_back(32'h0001_8233);
    tick();
    enq_valid = 1'b0;
    chk("t3_issue_a", issue_valid, 1);
    chk("t3_count_enq_and_issue", count, 1);
    chk("t3_state_blocked_by_issue", state, 2);
    tick();
    chk("t3_b_blocked", issue_valid, 0);
    chk("t3_state_ready", state, 1);
    tick();
    chk("t3_issue_b", issue_valid, 1);
    chk("t3_count_zero", count, 0);
    chk("t3_stall_cnt", stall_cnt, 4);

    // Fill to full under stall, reject the ninth, then drain in order.
    stall_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      v = plain(k);
      enq_valid = 1'b1; enq_instr = v; exp_q.push_back(v);
      tick();
    end
    chk("t4_full", full, 1);
    chk("t4_count8", count, 8);
    enq_instr = plain(8);
    #1 chk("t4_enq_ready_low", enq_ready, 0);
    tick();
    enq_valid = 1'b0;
    chk("t4_ninth_dropped", count, 8);
    stall_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_drain_valid", issue_valid, 1);
      chk("t4_drain_count", count, 32'(7 - i));
    end
    tick();
    chk("t4_drained_valid", issue_valid, 0);
    chk("t4_q_empty", exp_q.size(), 0);
    // Refill across the wrapped pointers.
    for (int k = 0; k < 3; k++) begin
      v = plain(20 + k);
      enq_valid = 1'b1; enq_instr = v; exp_q.push_back(v);
      tick();
    end
    enq_valid = 1'b0;
    tick();
    tick();
    chk("t4_refill_q_empty", exp_q.size(), 0);
    chk("t4_refill_count", count, 0);

    // Flush with five queued plus a simultaneous enqueue.
    stall_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v = plain(40 + k);
      enq_valid = 1'b1; enq_instr = v; exp_q.push_back(v);
      tick();
    end
    chk("t5_count5", count, 5);
    flush = 1'b1; enq_instr = 32'hDEAD_0013; exp_q.delete();
    tick();
    chk("t5_flush_count", count, 0);
    chk("t5_flush_valid", issue_valid, 0);
    chk("t5_flush_empty", empty, 1);
    flush = 1'b0; enq_valid = 1'b0; stall_in = 1'b0;
    tick();
    tick();
    chk("t5_lost_count", count, 0);
    chk("t5_lost_valid", issue_valid, 0);

    // Asynchronous reset between edges while an issue is presented.
    enq_valid = 1'b1; enq_instr = 32'h0050_0093; exp_q.push_back(32'h0050_0093);
    tick();
    enq_valid = 1'b0;
    tick();
    chk("t6_pre_valid", issue_valid, 1);
    #2 reset = 1'b0; exp_q.delete();
    #1;
    chk("t6_arst_valid", issue_valid, 0);
    chk("t6_arst_instr", issue_instr, 0);
    chk("t6_arst_count", count, 0);
    chk("t6_arst_state", state, 0);
    chk("t6_arst_stall_cnt", stall_cnt, 0);
    chk("t6_arst_empty", empty, 1);
    #2 reset = 1'b1;
    tick();
    chk("t6_post_valid", issue_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_issue_ctrl.md
DISPATCH_ISSUE_CTRL -- requirements
Module: dispatch_issue_ctrl

Interface
REQ-001 The block SHALL have parameter CORE, default 0, core identifier, not used in logic.
REQ-002 The block SHALL have parameter DEPTH, default 8, queue entries (power of two, at least 2).
REQ-003 The block SHALL have ports `clock  in  1  sole clock, rising edge`.
REQ-004 The block SHALL have port `reset  in  1  asynchronous, active-low reset`.
REQ-005 The block SHALL have ports `enq_valid in 1`, `enq_instr in 32` and `enq_ready out 1`: instruction enqueue handshake.
REQ-006 The block SHALL have ports `id_valid/exe_valid/mem_valid/wb_valid in 1` and `id_dest/exe_dest/mem_dest/wb_dest in 5`: in-flight destination registers.
REQ-007 The block SHALL have port `stall_in in 1`: downstream stall.
REQ-008 The block SHALL have port `flush in 1`: discard all queued and issued work.
REQ-009 The block SHALL have ports `issue_valid out 1` and `issue_instr out 32`: registered issue output.
REQ-010 The block SHALL have ports `count out log2(DEPTH)+1`, `full out 1` and `empty out 1`: queue occupancy.
REQ-011 The block SHALL have ports `state out 2` and `stall_cnt out 16`: debug/report.

Function
REQ-012 The block SHALL decode the head entry fields as rd=[11:7], rs1=[19:15] and rs2=[24:20]; these fields are used regardless of instruction format, which is conservative.
REQ-013 A source SHALL be hazardous when it is nonzero and equals the dest of any valid stage (ID/EXE/MEM/WB), or equals issue_instr[11:7] while issue_valid=1 and that rd is nonzero.
REQ-014 The queue SHALL be a circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
REQ-015 The block SHALL drive enq_ready = !full, combinationally; enqueue occurs on enq_valid && enq_ready.
REQ-016 An issue SHALL fire when the queue is not empty, there is no hazard, stall_in=0 and flush=0.
REQ-017 On an issue edge, the block SHALL set issue_instr to the head entry, set issue_valid to 1 and advance head.
REQ-018 On a non-issue edge, issue_valid SHALL be 0 and issue_instr SHALL hold its value.
REQ-019 Minimum latency SHALL be two edges: an entry written at edge N is eligible at edge N+1 and is never bypassed.
REQ-020 A simultaneous enqueue and issue SHALL leave count unchanged; both pointers advance.
REQ-021 When full, enq_valid SHALL be ignored, with no overwrite, even if an issue occurs in the same cycle.
REQ-022 flush=1 SHALL clear head, tail, count and issue_valid at the next edge, and SHALL discard any enqueue in that cycle.
REQ-023 The FSM SHALL have states EMPTY=0, READY=1 and STALL=2, registered.
REQ-024 Next state SHALL be EMPTY if the next count is 0.
REQ-025 Otherwise, next state SHALL be STALL if the head entry is blocked, by hazard or stall_in, in the next cycle's view as evaluated combinationally each cycle; else READY.
REQ-026 The `state` output SHALL reflect the current-cycle condition (registered one edge later is not allowed; `state` is computed from current count/hazard/stall_in).
REQ-027 stall_cnt SHALL increment by 1 on every edge where the queue is not empty and no issue fires; it saturates at 0xFFFF and is cleared only by reset.
REQ-028 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).

Reset
REQ-029 When reset=0, the block SHALL immediately clear head, tail, count, issue_valid, issue_instr and stall_cnt to 0, with state=EMPTY; queue contents need not be cleared.
REQ-030 Reset asserted mid-operation SHALL drop all queued instructions with no partial issue.
REQ-031 On the first edge after reset deassertion, the block SHALL accept an enqueue.

Verification
REQ-032 Enqueue 0x00208133 (add x2,x1,x2) with all stages idle -> issue_valid=1 with that instruction two edges later, then count=0 and empty=1.
REQ-033 Head rs1=x5 with exe_valid=1 and exe_dest=5 for 3 cycles -> state=STALL, no issue, stall_cnt=3; the instruction issues on the edge after exe_valid drops.
REQ-034 Back-to-back enqueue of "addi x3" then "add x4,x3,x0" -> the first issues and the second is blocked by issue_instr rd=3 for one cycle even with ID idle.
REQ-035 Enqueue 9 instructions with stall_in=1 -> full=1 after 8, the 9th enq_ready=0 and is not stored; release stall_in -> 8 issue in order, and pointers wrap correctly on refill.
REQ-036 Queue holding 5 entries, assert flush together with enq_valid -> count=0, issue_valid=0 at the next edge, and the enqueued instruction is lost.
REQ-037 Assert reset low asynchronously, between edges, while issue_valid=1 -> outputs clear without a clock edge.
